packet_parser: RTL and testbench
================================

Name: packet_parser

Overview:
- Sits between the UART receiver and the ALU.
- Consumes the raw received byte stream and frames each packet as: opcode byte, reserved byte, 16-bit little-endian total length, then payload.
- Assembles the payload into 32-bit little-endian operand words and hands them to the ALU, one word at a time, over a valid/ready handshake.
- Rejects malformed packets and skips the rest of their bytes, so the next packet is parsed from a clean boundary.

Parameters:
- MAX_LEN, 16'd1024: largest accepted total packet length in bytes, header included.
- TIMEOUT_CYCLES, 32'd1_000_000: maximum idle cycles allowed between bytes inside a packet. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle strobe marking rx_data_i valid. No backpressure is possible.
- opcode_o  out  8  opcode of the current packet. Held stable from the LEN_LO state until the next packet's opcode byte.
- operand_o  out  32  assembled operand word; payload byte k maps to bits [8k+7:8k].
- operand_bytes_o  out  3  number of valid bytes in operand_o, 1..4.
- operand_first_o  out  1  high when operand_o is the first word of the packet.
- operand_last_o  out  1  high when operand_o is the final word of the packet.
- operand_valid_o  out  1  operand_o is valid.
- operand_ready_i  in  1  ALU accepts the word. A transfer occurs when valid and ready are both high.
- error_o  out  1  one-cycle pulse on any packet rejection.
- err_code_o  out  2  reason for the most recent rejection: 0 bad opcode, 1 bad length, 2 overrun, 3 timeout. Holds until the next error.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; all outputs 0; byte counters cleared.
- States and transitions:
  - IDLE: a byte arrives → latch it as the opcode → RSVD.
  - RSVD: the reserved byte is discarded → LEN_LO.
  - LEN_LO: latch the low length byte → LEN_HI.
  - LEN_HI: latch the high length byte, then validate. Valid → DATA. Invalid → pulse error_o, then DRAIN with (len-4) bytes to skip, or straight to IDLE if nothing remains to skip.
  - DATA: shift each byte into the assembly register.
    - A word completes when 4 bytes are collected, or on the final payload byte (partial word).
    - On completion, copy the word to the output register and raise operand_valid_o on the next cycle (1-cycle latency from the completing byte).
    - After the final byte, the parser returns to IDLE, or stays in a WAIT state while the last word is still unaccepted.
  - DRAIN: count down the skipped bytes, then → IDLE.
- Valid opcodes: 0xEC echo, 0xAD add, 0xAC multiply, 0xD1 divide. Any other value → err_code 0.
- Length rules (otherwise err_code 1):
  - General: 4 < len ≤ MAX_LEN.
  - 0xAD and 0xAC: (len-4) must be a multiple of 4.
  - 0xD1: len must equal exactly 12.
  - 0xEC: any payload length is accepted; the last word may be partial.
- Output hold: operand_valid_o stays high, and all operand fields stay stable, until a transfer occurs.
- Overrun: a new word completes while the previous word is still unaccepted.
  - Pulse error_o with err_code 2.
  - Drop the pending word (valid → 0).
  - DRAIN any remaining payload bytes.
- A completing byte that lands in the same cycle as the transfer of the pending word is not an overrun. The new word loads on the next cycle.
- Bytes arriving while in WAIT are treated as the start of the next packet, i.e. an opcode byte. The parser latches the opcode and proceeds normally.
- Reset mid-packet: all state is discarded immediately; the first byte after reset release is parsed as an opcode.

Optional Feature:
- Macro: PACKET_PARSER_TIMEOUT_EN.
- When defined:
  - A counter clears on every rx_valid_i.
  - In the RSVD, LEN_LO, LEN_HI, DATA and DRAIN states, once TIMEOUT_CYCLES idle cycles elapse: pulse error_o with err_code 3, drop any pending word, and return to IDLE.
- When undefined: no counter exists; the parser waits indefinitely between bytes and err_code 3 is never produced.

Test Plan:
- Add packet: send AD 00 0C 00 01 00 00 00 02 00 00 00 with operand_ready_i held at 1.
  - Expect word 0x00000001 with first=1, last=0, bytes=4.
  - Then word 0x00000002 with first=0, last=1.
  - error_o stays 0.
- Echo packet with partial word: send EC 00 0B 00 61 62 63 64 65 66 67.
  - Expect word 0x64636261 (bytes=4).
  - Then word 0x00676665 with bytes=3 and last=1.
- Bad opcode: send 55 00 08 00 AA BB CC DD, then a valid add packet.
  - Expect an error_o pulse with err_code 0, the 4 payload bytes drained, and the following packet parsed correctly.
- Divide with bad length: send D1 00 10 00 plus 12 payload bytes.
  - Expect err_code 1, no operand_valid_o, and a return to IDLE after the 12 bytes.
- Overrun: send an add packet with 3 words while operand_ready_i is held at 0.
  - Expect err_code 2 when the second word completes, operand_valid_o dropped, and the rest of the packet drained.
- Reset mid-DATA: assert rst after 6 bytes of an add packet.
  - Expect all outputs 0 immediately.
  - The next packet AC 00 08 00 03 00 00 00 yields word 3 with last=1.

Source files
------------

// File: rtl/packet_parser.sv
// packet_parser
//   Frames the raw UART byte stream into packets and feeds their payload to
//   the ALU as 32-bit little-endian operand words over a valid/ready handshake.
//   Packet layout: opcode, reserved byte, 16-bit little-endian total length
//   (header included), then payload. Malformed packets are flagged and their
//   remaining bytes skipped so the next packet starts on a clean boundary.
//
//   Optional feature: define PACKET_PARSER_TIMEOUT_EN to abort a packet when
//   TIMEOUT_CYCLES idle cycles pass between bytes (err_code 3).
//
// Ports
//   clk              system clock
//   rst              asynchronous active-low reset
//   rx_data_i        received byte
//   rx_valid_i       one-cycle strobe qualifying rx_data_i
//   opcode_o         opcode of the current packet
//   operand_o        assembled operand word (payload byte k -> bits [8k+7:8k])
//   operand_bytes_o  valid bytes in operand_o (1..4)
//   operand_first_o  operand_o is the first word of the packet
//   operand_last_o   operand_o is the last word of the packet
//   operand_valid_o  operand_o is valid
//   operand_ready_i  ALU accepts the word
//   error_o          one-cycle pulse on a packet rejection
//   err_code_o       reason of the latest rejection: 0 opcode, 1 length,
//                    2 overrun, 3 timeout
`timescale 1ns/1ps
module packet_parser #(
  parameter logic [15:0] MAX_LEN        = 16'd1024,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  opcode_o,
  output logic [31:0] operand_o,
  output logic [2:0]  operand_bytes_o,
  output logic        operand_first_o,
  output logic        operand_last_o,
  output logic        operand_valid_o,
  input  logic        operand_ready_i,
  output logic        error_o,
  output logic [1:0]  err_code_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RSVD   = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] LEN_HI = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] WAIT   = 3'd5;
  localparam logic [2:0] DRAIN  = 3'd6;

  logic [2:0]  state;
  logic [7:0]  len_lo;
  logic [15:0] remaining;   // payload bytes still expected (DATA) or to skip (DRAIN)
  logic [1:0]  byte_idx;
  logic [31:0] assemble;
  logic        first_pending;

  logic [15:0] full_len;
  logic [15:0] payload_len;
  logic        opcode_ok;
  logic        len_ok;
  logic        last_byte;
  logic        word_done;
  logic        transfer;
  logic [31:0] next_word;

  // Header validation uses the high length byte directly from rx_data_i so the
  // decision is taken in the same cycle that byte arrives.
  always_comb begin
    full_len    = {rx_data_i, len_lo};
    payload_len = full_len - 16'd4;
    opcode_ok   = 1'b0;
    len_ok      = 1'b0;
    case (opcode_o)
      8'hEC: begin
        opcode_ok = 1'b1;
        len_ok    = 1'b1;
      end
      // (len-4) multiple of 4 is the same as len multiple of 4
      8'hAD, 8'hAC: begin
        opcode_ok = 1'b1;
        len_ok    = (full_len[1:0] == 2'b00);
      end
      8'hD1: begin
        opcode_ok = 1'b1;
        len_ok    = (full_len == 16'd12);
      end
      default: begin
        opcode_ok = 1'b0;
        len_ok    = 1'b0;
      end
    endcase
    len_ok    = len_ok && (full_len > 16'd4) && (full_len <= MAX_LEN);
    last_byte = (remaining == 16'd1);
    word_done = (state == DATA) && rx_valid_i && ((byte_idx == 2'd3) || last_byte);
    next_word = assemble | ({24'd0, rx_data_i} << {byte_idx, 3'b000});
    transfer  = operand_valid_o && operand_ready_i;
  end

`ifdef PACKET_PARSER_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        timed_state;
  logic        timeout_hit;

  assign timed_state = (state == RSVD) || (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA) || (state == DRAIN);
  assign timeout_hit = timed_state && !rx_valid_i && (idle_cnt >= TIMEOUT_CYCLES - 32'd1);

  // Idle-cycle counter; only runs while a packet is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= 32'd0;
    end else if (rx_valid_i || !timed_state || timeout_hit) begin
      idle_cnt <= 32'd0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`endif

  // Parser FSM, word assembly and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      len_lo          <= 8'd0;
      remaining       <= 16'd0;
      byte_idx        <= 2'd0;
      assemble        <= 32'd0;
      first_pending   <= 1'b0;
      opcode_o        <= 8'd0;
      operand_o       <= 32'd0;
      operand_bytes_o <= 3'd0;
      operand_first_o <= 1'b0;
      operand_last_o  <= 1'b0;
      operand_valid_o <= 1'b0;
      error_o         <= 1'b0;
      err_code_o      <= 2'd0;
    end else begin
      error_o <= 1'b0;
      if (transfer) begin
        operand_valid_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (rx_valid_i) begin
            opcode_o <= rx_data_i;
            state    <= RSVD;
          end
        end
        RSVD: begin
          if (rx_valid_i) begin
            state <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (rx_valid_i) begin
            len_lo <= rx_data_i;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (rx_valid_i) begin
            remaining <= payload_len;
            if (opcode_ok && len_ok) begin
              byte_idx      <= 2'd0;
              assemble      <= 32'd0;
              first_pending <= 1'b1;
              state         <= DATA;
            end else begin
              error_o    <= 1'b1;
              err_code_o <= opcode_ok ? 2'd1 : 2'd0;
              state      <= (full_len > 16'd4) ? DRAIN : IDLE;
            end
          end
        end
        DATA: begin
          if (rx_valid_i) begin
            remaining <= remaining - 16'd1;
            byte_idx  <= byte_idx + 2'd1;
            if (word_done) begin
              assemble <= 32'd0;
              byte_idx <= 2'd0;
              // A word still waiting and not being taken this cycle is lost.
              if (operand_valid_o && !operand_ready_i) begin
                error_o         <= 1'b1;
                err_code_o      <= 2'd2;
                operand_valid_o <= 1'b0;
                state           <= last_byte ? IDLE : DRAIN;
              end else begin
                operand_o       <= next_word;
                operand_bytes_o <= {1'b0, byte_idx} + 3'd1;
                operand_first_o <= first_pending;
                operand_last_o  <= last_byte;
                operand_valid_o <= 1'b1;
                first_pending   <= 1'b0;
                if (last_byte) begin
                  state <= WAIT;
                end
              end
            end else begin
              assemble <= next_word;
            end
          end
        end
        // A byte here already belongs to the next packet.
        WAIT: begin
          if (rx_valid_i) begin
            opcode_o <= rx_data_i;
            state    <= RSVD;
          end else if (!operand_valid_o || transfer) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (rx_valid_i) begin
            remaining <= remaining - 16'd1;
            if (remaining <= 16'd1) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
`ifdef PACKET_PARSER_TIMEOUT_EN
      if (timeout_hit) begin
        error_o         <= 1'b1;
        err_code_o      <= 2'd3;
        operand_valid_o <= 1'b0;
        state           <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_packet_parser.sv
// tb_packet_parser
//   Directed self-checking bench for packet_parser. Expected operand words are
//   queued when a packet is driven and checked as the ALU side accepts them;
//   error pulses are captured and checked after each step.
`timescale 1ns/1ps
module tb_packet_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  opcode_o;
  logic [31:0] operand_o;
  logic [2:0]  operand_bytes_o;
  logic        operand_first_o;
  logic        operand_last_o;
  logic        operand_valid_o;
  logic        operand_ready_i;
  logic        error_o;
  logic [1:0]  err_code_o;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  bytes;
    logic        first;
    logic        last;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] err_q[$];
  logic [7:0] pkt[$];
  int         n_compared;
  int         n_mismatched;

  packet_parser dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data_i       (rx_data_i),
    .rx_valid_i      (rx_valid_i),
    .opcode_o        (opcode_o),
    .operand_o       (operand_o),
    .operand_bytes_o (operand_bytes_o),
    .operand_first_o (operand_first_o),
    .operand_last_o  (operand_last_o),
    .operand_valid_o (operand_valid_o),
    .operand_ready_i (operand_ready_i),
    .error_o         (error_o),
    .err_code_o      (err_code_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input logic [2:0] b, input logic f, input logic l);
    exp_t e;
    e.word  = w;
    e.bytes = b;
    e.first = f;
    e.last  = l;
    sb_q.push_back(e);
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++) begin
      send_byte(pkt[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_error(input string tag, input logic [1:0] code);
    idle(3);
    check({tag, "_err_count"}, 32'(err_q.size()), 32'd1);
    if (err_q.size() > 0) begin
      check({tag, "_err_code"}, 32'(err_q.pop_front()), 32'(code));
    end
    check({tag, "_err_hold"}, 32'(err_code_o), 32'(code));
  endtask

  task automatic expect_quiet(input string tag);
    idle(6);
    check({tag, "_no_error"}, 32'(err_q.size()), 32'd0);
    check({tag, "_words_done"}, 32'(sb_q.size()), 32'd0);
    err_q.delete();
  endtask

  // Every accepted word is checked against the head of the scoreboard.
  always @(negedge clk) begin : word_monitor
    exp_t e;
    if (rst && operand_valid_o && operand_ready_i) begin
      n_compared++;
      assert (sb_q.size() != 0) else begin
        n_mismatched++;
        $error("[TB] FAIL unexpected_word observed=0x%0h expected=none", operand_o);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("word",  operand_o, e.word);
        check("bytes", 32'(operand_bytes_o), 32'(e.bytes));
        check("first", 32'(operand_first_o), 32'(e.first));
        check("last",  32'(operand_last_o),  32'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && error_o) begin
      err_q.push_back(err_code_o);
    end
  end

  initial begin
    n_compared      = 0;
    n_mismatched    = 0;
    rst             = 1'b0;
    rx_data_i       = 8'd0;
    rx_valid_i      = 1'b0;
    operand_ready_i = 1'b1;
    idle(3);

    check("rst_opcode", 32'(opcode_o), 32'd0);
    check("rst_valid",  32'(operand_valid_o), 32'd0);
    check("rst_operand", operand_o, 32'd0);
    check("rst_error",  32'(error_o), 32'd0);
    check("rst_errcode", 32'(err_code_o), 32'd0);
    rst = 1'b1;
    idle(1);

    $display("[TB] add packet, ready held high");
    push_word(32'h0000_0001, 3'd4, 1'b1, 1'b0);
    push_word(32'h0000_0002, 3'd4, 1'b0, 1'b1);
    pkt = {8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt();
    check("add_opcode", 32'(opcode_o), 32'hAD);
    expect_quiet("add");

    $display("[TB] echo packet with partial last word");
    push_word(32'h6463_6261, 3'd4, 1'b1, 1'b0);
    push_word(32'h0067_6665, 3'd3, 1'b0, 1'b1);
    pkt = {8'hEC, 8'h00, 8'h0B, 8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
    send_pkt();
    expect_quiet("echo");

    $display("[TB] bad opcode then add packet");
    pkt = {8'h55, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_pkt();
    expect_error("badop", 2'd0);
    push_word(32'h0000_0005, 3'd4, 1'b1, 1'b1);
    pkt = {8'hAD, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt();
    expect_quiet("after_badop");

    $display("[TB] divide with bad length, then valid divide");
    pkt = {8'hD1, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
           8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    send_pkt();
    expect_error("divlen", 2'd1);
    check("divlen_no_valid", 32'(operand_valid_o), 32'd0);
    push_word(32'h4433_2211, 3'd4, 1'b1, 1'b0);
    push_word(32'h8877_6655, 3'd4, 1'b0, 1'b1);
    pkt = {8'hD1, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt();
    expect_quiet("div");

    $display("[TB] length of exactly 4 is rejected without drain");
    pkt = {8'hEC, 8'h00, 8'h04, 8'h00};
    send_pkt();
    expect_error("len4", 2'd1);
    push_word(32'h0000_005A, 3'd1, 1'b1, 1'b1);
    pkt = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    send_pkt();
    expect_quiet("after_len4");

    $display("[TB] completing byte coincides with transfer");
    push_word(32'h0000_0001, 3'd4, 1'b1, 1'b0);
    push_word(32'h0000_0002, 3'd4, 1'b0, 1'b1);
    operand_ready_i = 1'b0;
    pkt = {8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
    send_pkt();
    check("hold_valid", 32'(operand_valid_o), 32'd1);
    check("hold_word", operand_o, 32'h0000_0001);
    operand_ready_i = 1'b1;
    send_byte(8'h00);
    expect_quiet("sametick");

    $display("[TB] next packet starts while last word waits");
    operand_ready_i = 1'b0;
    push_word(32'h0000_0041, 3'd1, 1'b1, 1'b1);
    push_word(32'h0000_0007, 3'd4, 1'b1, 1'b1);
    pkt = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h41, 8'hAD, 8'h00, 8'h08, 8'h00};
    send_pkt();
    check("wait_opcode", 32'(opcode_o), 32'hAD);
    check("wait_held", operand_o, 32'h0000_0041);
    operand_ready_i = 1'b1;
    idle(2);
    pkt = {8'h07, 8'h00, 8'h00, 8'h00};
    send_pkt();
    expect_quiet("wait");

    $display("[TB] overrun with ready low");
    operand_ready_i = 1'b0;
    pkt = {8'hAD, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    send_pkt();
    check("ovr_first_valid", 32'(operand_valid_o), 32'd1);
    check("ovr_first_word", operand_o, 32'h0000_0001);
    pkt = {8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    send_pkt();
    expect_error("overrun", 2'd2);
    check("ovr_dropped", 32'(operand_valid_o), 32'd0);
    operand_ready_i = 1'b1;
    push_word(32'h0000_0009, 3'd4, 1'b1, 1'b1);
    pkt = {8'hAC, 8'h00, 8'h08, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00};
    send_pkt();
    expect_quiet("after_overrun");

    $display("[TB] reset in the middle of a payload");
    pkt = {8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
    send_pkt();
    rst = 1'b0;
    #1;
    check("mid_rst_opcode", 32'(opcode_o), 32'd0);
    check("mid_rst_operand", operand_o, 32'd0);
    check("mid_rst_valid", 32'(operand_valid_o), 32'd0);
    check("mid_rst_errcode", 32'(err_code_o), 32'd0);
    check("mid_rst_last", 32'(operand_last_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    push_word(32'h0000_0003, 3'd4, 1'b1, 1'b1);
    pkt = {8'hAC, 8'h00, 8'h08, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    send_pkt();
    expect_quiet("after_rst");

    idle(10);
    check("final_words", 32'(sb_q.size()), 32'd0);
    check("final_errors", 32'(err_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
